// File: rtl/ristretto_exe_stage_pkg.sv
// Shared execute-stage types: shift operation encodings, the shifter stage
// payload layout and small mode-decoding helpers used by the shifter.
package ristretto_exe_stage_pkg;

  // 3-bit shift mode; the old 2-bit encodings sit on the low bits.
  typedef enum logic [2:0] {
    SHIFT_LEFT   = 3'b000,
    SHIFT_RIGHT  = 3'b010,
    SHIFT_ARIGHT = 3'b011,
    SHIFT_ROL    = 3'b100,
    SHIFT_ROR    = 3'b110
  } shift_mode_e;

  localparam int ShiftDataWidth = 32;
  localparam int ShiftTagWidth  = 5;
  localparam int ShiftAmtWidth  = $clog2(ShiftDataWidth);

  // Payload held by every shifter pipeline stage at the default widths.
  typedef struct packed {
    logic                     valid;
    logic [ShiftDataWidth-1:0] data;
    logic [ShiftAmtWidth-1:0]  amt;
    shift_mode_e              mode;
    logic                     fill;
    logic [ShiftTagWidth-1:0]  tag;
  } shift_stage_t;

  // Left shifts and left rotates run through the right datapath bit-reversed.
  function automatic logic is_left(input shift_mode_e mode);
    return (mode == SHIFT_LEFT) || (mode == SHIFT_ROL);
  endfunction

  // Rotates refill the vacated bits with the bits shifted out.
  function automatic logic is_rotate(input shift_mode_e mode);
    return (mode == SHIFT_ROL) || (mode == SHIFT_ROR);
  endfunction

  // Reserved codes are treated as a pass-through with a zero amount.
  function automatic logic is_known(input shift_mode_e mode);
    logic known;
    known = 1'b0;
    case (mode)
      SHIFT_LEFT, SHIFT_RIGHT, SHIFT_ARIGHT, SHIFT_ROL, SHIFT_ROR: known = 1'b1;
      default: known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/ristretto_shift_slice.sv
// Combinational slice of the right-shift datapath: applies log2 steps
// FirstStep .. FirstStep+NumSteps-1, each step gated by its amount bit.
module ristretto_shift_slice #(
  parameter int DataWidth = 32,
  parameter int FirstStep = 0,
  parameter int NumSteps  = 1
) (
  input  logic [DataWidth-1:0] data,
  input  logic [NumSteps-1:0]  amt,
  input  logic                 rotate,
  input  logic                 fill,
  output logic [DataWidth-1:0] result
);

  logic [NumSteps:0][DataWidth-1:0] step_data;

  assign step_data[0] = data;

  for (genvar j = 0; j < NumSteps; j++) begin : g_step
    localparam int Shift = 1 << (FirstStep + j);
    logic [DataWidth-1:0] shifted;
    logic [DataWidth-1:0] wrap_bits;
    logic [DataWidth-1:0] fill_bits;

    assign shifted   = step_data[j] >> Shift;
    assign wrap_bits = step_data[j] << (DataWidth - Shift);
    assign fill_bits = fill ? ~({DataWidth{1'b1}} >> Shift) : '0;
    assign step_data[j+1] = amt[j] ? (shifted | (rotate ? wrap_bits : fill_bits))
                                   : step_data[j];
  end

  assign result = step_data[NumSteps];

endmodule

// File: rtl/ristretto_pipelined_shifter.sv
// Pipelined barrel shifter for the execute stage. Operands flow through
// Latency register stages under a single global stall; left modes are
// bit-reversed on entry and on the way into the last stage register.
module ristretto_pipelined_shifter
  import ristretto_exe_stage_pkg::*;
#(
  parameter int DataWidth      = 32,
  parameter int StagesPerCycle = 2,
  parameter int TagWidth       = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         shft_valid_i,
  output logic                         shft_ready_o,
  input  logic [DataWidth-1:0]         shft_data_i,
  input  logic [$clog2(DataWidth)-1:0] shft_amt_i,
  input  logic [2:0]                   shft_mode_i,
  input  logic [TagWidth-1:0]          shft_tag_i,
  input  logic                         shft_flush_i,
  output logic                         shft_valid_o,
  input  logic                         shft_ready_i,
  output logic [DataWidth-1:0]         shft_result_o,
  output logic [TagWidth-1:0]          shft_tag_o,
  output logic                         shft_busy_o
);

  localparam int NumStages = $clog2(DataWidth);
  localparam int Latency   = (NumStages + StagesPerCycle - 1) / StagesPerCycle;

  typedef struct packed {
    logic                 valid;
    logic [DataWidth-1:0] data;
    logic [NumStages-1:0] amt;
    shift_mode_e          mode;
    logic                 fill;
    logic [TagWidth-1:0]  tag;
  } stage_t;

  function automatic logic [DataWidth-1:0] reverse_bits(input logic [DataWidth-1:0] v);
    logic [DataWidth-1:0] r;
    for (int i = 0; i < DataWidth; i++) r[i] = v[DataWidth-1-i];
    return r;
  endfunction

  stage_t      stage_q [Latency];
  stage_t      stage_d [Latency];
  stage_t      issue;
  shift_mode_e in_mode;
  logic        adv;

  assign in_mode = shift_mode_e'(shft_mode_i);
  assign adv     = ~stage_q[Latency-1].valid | shft_ready_i;

  // Build the stage-0 payload: capture the sign before reversal, zero the
  // amount for reserved codes so they pass straight through.
  always_comb begin
    issue       = '0;
    issue.valid = shft_valid_i;
    issue.mode  = in_mode;
    issue.tag   = shft_tag_i;
    issue.fill  = (in_mode == SHIFT_ARIGHT) & shft_data_i[DataWidth-1];
    issue.amt   = is_known(in_mode) ? shft_amt_i : '0;
    issue.data  = is_left(in_mode) ? reverse_bits(shft_data_i) : shft_data_i;
  end

  for (genvar k = 0; k < Latency; k++) begin : g_stage
    localparam int First = k * StagesPerCycle;
    localparam int Last  = ((k + 1) * StagesPerCycle > NumStages) ? NumStages
                                                                   : (k + 1) * StagesPerCycle;
    stage_t               stage_in;
    stage_t               stage_out;
    logic [DataWidth-1:0] sliced;

    if (k == 0) begin : g_first
      assign stage_in = issue;
    end else begin : g_next
      assign stage_in = stage_q[k-1];
    end

    ristretto_shift_slice #(
      .DataWidth(DataWidth),
      .FirstStep(First),
      .NumSteps (Last - First)
    ) u_slice (
      .data  (stage_in.data),
      .amt   (stage_in.amt[Last-1:First]),
      .rotate(is_rotate(stage_in.mode)),
      .fill  (stage_in.fill),
      .result(sliced)
    );

    // Next value for this stage; the last stage undoes the left-mode reversal.
    always_comb begin
      stage_out      = stage_in;
      stage_out.data = sliced;
      if ((k == Latency - 1) && is_left(stage_in.mode)) stage_out.data = reverse_bits(sliced);
    end

    assign stage_d[k] = stage_out;
  end

  // Pipeline registers: advance together when unstalled, flush clears valids.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < Latency; k++) stage_q[k] <= '0;
    end else begin
      if (adv) begin
        for (int k = 0; k < Latency; k++) stage_q[k] <= stage_d[k];
      end
      if (shft_flush_i) begin
        for (int k = 0; k < Latency; k++) stage_q[k].valid <= 1'b0;
      end
    end
  end

  // Busy whenever any slot carries a live operation.
  always_comb begin
    shft_busy_o = 1'b0;
    for (int k = 0; k < Latency; k++) shft_busy_o = shft_busy_o | stage_q[k].valid;
  end

  assign shft_ready_o  = adv;
  assign shft_valid_o  = stage_q[Latency-1].valid;
  assign shft_result_o = stage_q[Latency-1].data;
  assign shft_tag_o    = stage_q[Latency-1].tag;

endmodule
